// File: rtl/inter_send_arbiter.sv
// Round-robin owner of the single interboard transmitter: one message in flight,
// timeout-driven re-issue, and a done/err pulse back to the requester that owned it.
module inter_send_arbiter #(
   parameter int unsigned N         = 4,
   parameter int unsigned MSG_W     = 22,
   parameter int unsigned TIMEOUT   = 1023,
   parameter int unsigned MAX_RETRY = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 interboard_rst,
   input  logic [N-1:0]         req,
   input  logic [N*MSG_W-1:0]   req_msg,
   input  logic                 inter_ready,
   output logic                 inter_en,
   output logic [MSG_W-1:0]     inter_msg,
   output logic [N-1:0]         grant,
   output logic [N-1:0]         done,
   output logic                 err,
   output logic                 busy
);

   localparam int unsigned PW = $clog2(N);
   localparam int unsigned TW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_COMPLETE
   } state_t;

   state_t          state;
   logic [PW-1:0]   rr_ptr;
   logic [TW-1:0]   timer;
   logic [2:0]      retry_cnt;

   logic            win_found;
   logic [PW-1:0]   win_idx;
   logic [PW-1:0]   scan_idx;
   logic [N-1:0]    win_onehot;
   int unsigned     scan_pos;

   // Search upward starting just after the last winner, wrapping modulo N.
   always_comb begin
      win_found  = 1'b0;
      win_idx    = '0;
      scan_idx   = '0;
      scan_pos   = 0;
      win_onehot = '0;
      for (int unsigned i = 1; i <= N; i++) begin
         scan_pos = (32'(rr_ptr) + i) % N;
         scan_idx = PW'(scan_pos);
         if (!win_found && req[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = scan_idx;
         end
      end
      win_onehot[win_idx] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         rr_ptr    <= PW'(N - 1);
         timer     <= '0;
         retry_cnt <= '0;
         inter_en  <= 1'b0;
         inter_msg <= '0;
         grant     <= '0;
         done      <= '0;
         err       <= 1'b0;
         busy      <= 1'b0;
      end else if (interboard_rst) begin
         state     <= S_IDLE;
         rr_ptr    <= PW'(N - 1);
         timer     <= '0;
         retry_cnt <= '0;
         inter_en  <= 1'b0;
         inter_msg <= '0;
         grant     <= '0;
         done      <= '0;
         err       <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= '0;
               err  <= 1'b0;
               if (win_found) begin
                  inter_msg <= req_msg[32'(win_idx) * MSG_W +: MSG_W];
                  grant     <= win_onehot;
                  rr_ptr    <= win_idx;
                  inter_en  <= 1'b1;
                  busy      <= 1'b1;
                  state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               inter_en <= 1'b0;
               timer    <= '0;
               state    <= S_WAIT;
            end
            S_WAIT: begin
               timer <= timer + 1'b1;
               // Completion takes precedence over a timeout in the same cycle.
               if (inter_ready) begin
                  done  <= grant;
                  err   <= 1'b0;
                  state <= S_COMPLETE;
               end else if (timer == TW'(TIMEOUT - 1)) begin
                  if (retry_cnt < 3'(MAX_RETRY)) begin
                     retry_cnt <= retry_cnt + 1'b1;
                     inter_en  <= 1'b1;
                     state     <= S_ISSUE;
                  end else begin
                     done  <= grant;
                     err   <= 1'b1;
                     state <= S_COMPLETE;
                  end
               end
            end
            S_COMPLETE: begin
               done      <= '0;
               err       <= 1'b0;
               retry_cnt <= '0;
               grant     <= '0;
               busy      <= 1'b0;
               state     <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inter_send_arbiter.sv
// Directed and randomized transactions against a transaction-level timeline model
// of inter_send_arbiter (N=4, TIMEOUT=8, MAX_RETRY=2).
module tb_inter_send_arbiter;

   localparam int N     = 4;
   localparam int MSG_W = 22;
   localparam int T     = 8;
   localparam int MR    = 2;

   logic                 clk;
   logic                 rst;
   logic                 interboard_rst;
   logic [N-1:0]         req;
   logic [N*MSG_W-1:0]   req_msg;
   logic                 inter_ready;
   logic                 inter_en;
   logic [MSG_W-1:0]     inter_msg;
   logic [N-1:0]         grant;
   logic [N-1:0]         done;
   logic                 err;
   logic                 busy;

   int checks   = 0;
   int failures = 0;
   int m_ptr;
   logic [N-1:0] last_grant;

   inter_send_arbiter #(
      .N(N),
      .MSG_W(MSG_W),
      .TIMEOUT(T),
      .MAX_RETRY(MR)
   ) dut (
      .clk(clk),
      .rst(rst),
      .interboard_rst(interboard_rst),
      .req(req),
      .req_msg(req_msg),
      .inter_ready(inter_ready),
      .inter_en(inter_en),
      .inter_msg(inter_msg),
      .grant(grant),
      .done(done),
      .err(err),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Round-robin rule: first requester above the last winner, wrapping.
   function automatic int pick(input logic [N-1:0] r, input int ptr);
      for (int k = 1; k <= N; k++)
         if (r[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   task automatic randomize_msgs();
      for (int i = 0; i < N; i++) req_msg[i*MSG_W +: MSG_W] = MSG_W'($urandom);
   endtask

   // att: attempt index on which inter_ready arrives (att > MR means never);
   // dly: WAIT-cycle index within that attempt. Caller has set req_msg.
   task automatic run_txn(input logic [N-1:0] rq, input int att, input int dly, input bit noise);
      int w, ready_off, done_off, last_att;
      bit exp_err, is_issue;
      logic [MSG_W-1:0] exp_msg;
      logic [N-1:0] oh;
      req = rq;
      inter_ready = 1'b0;
      w = pick(rq, m_ptr);
      m_ptr = w;
      oh = '0;
      oh[w] = 1'b1;
      exp_msg = req_msg[w*MSG_W +: MSG_W];
      if (att > MR) begin
         ready_off = -1;
         last_att  = MR;
         done_off  = 2 + MR * (T + 1) + T;
         exp_err   = 1'b1;
      end else begin
         last_att  = att;
         ready_off = 2 + att * (T + 1) + dly;
         done_off  = ready_off + 1;
         exp_err   = 1'b0;
      end
      for (int c = 1; c <= done_off; c++) begin
         tick();
         is_issue = ((c - 1) % (T + 1) == 0) && ((c - 1) / (T + 1) <= last_att) && (c < done_off);
         chk("inter_en", inter_en, is_issue);
         chk("grant", grant, oh);
         chk("busy", busy, 1'b1);
         chk("inter_msg", inter_msg, exp_msg);
         chk("done", done, (c == done_off) ? oh : '0);
         chk("err", err, (c == done_off) ? exp_err : 1'b0);
         last_grant = grant;
         inter_ready = (c == ready_off) || (noise && (is_issue || c == done_off) && ($urandom_range(1) == 1));
         if (noise) begin
            req = N'($urandom);
            randomize_msgs();
         end
         if (c == done_off) req = '0;
      end
      tick();
      chk("idle_busy", busy, 1'b0);
      chk("idle_grant", grant, '0);
      chk("idle_done", done, '0);
      chk("idle_err", err, 1'b0);
      chk("idle_en", inter_en, 1'b0);
      inter_ready = 1'b0;
   endtask

   task automatic idle_cycles(input int n, input bit stray);
      for (int i = 0; i < n; i++) begin
         req = '0;
         inter_ready = stray ? ($urandom_range(1) == 1) : 1'b0;
         tick();
         chk("quiet_busy", busy, 1'b0);
         chk("quiet_grant", grant, '0);
         chk("quiet_en", inter_en, 1'b0);
         chk("quiet_done", done, '0);
      end
      inter_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      interboard_rst = 1'b0;
      req = '0;
      req_msg = '0;
      inter_ready = 1'b0;
      m_ptr = N - 1;
      last_grant = '0;
      tick();
      chk("rst_busy", busy, 1'b0);
      chk("rst_grant", grant, '0);
      chk("rst_msg", inter_msg, '0);
      chk("rst_en", inter_en, 1'b0);
      chk("rst_done", done, '0);
      chk("rst_err", err, 1'b0);
      rst = 1'b0;
      tick();

      // Single request with ready at t+5.
      randomize_msgs();
      req_msg[2*MSG_W +: MSG_W] = 22'h2A5C3;
      run_txn(4'b0100, 0, 3, 1'b0);
      chk("t1_grant", last_grant, 4'b0100);

      // Round robin on a full request set, then 0 and 3 only.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_ptr = N - 1;
      randomize_msgs();
      run_txn(4'b1111, 0, 1, 1'b0);
      chk("rr0", last_grant, 4'b0001);
      run_txn(4'b1110, 0, 1, 1'b0);
      chk("rr1", last_grant, 4'b0010);
      run_txn(4'b1100, 0, 1, 1'b0);
      chk("rr2", last_grant, 4'b0100);
      run_txn(4'b1000, 0, 1, 1'b0);
      chk("rr3", last_grant, 4'b1000);
      run_txn(4'b1001, 0, 1, 1'b0);
      chk("rr_b0", last_grant, 4'b0001);
      run_txn(4'b1000, 0, 1, 1'b0);
      chk("rr_b3", last_grant, 4'b1000);

      // Full timeout with retries exhausted, then ready on the timeout cycle.
      randomize_msgs();
      run_txn(4'b0010, MR + 1, 0, 1'b0);
      randomize_msgs();
      run_txn(4'b1000, 0, T - 1, 1'b0);
      idle_cycles(4, 1'b1);

      // Noisy requests/messages while busy; withdrawn requests never granted.
      randomize_msgs();
      run_txn(4'b0001, 1, 2, 1'b1);
      idle_cycles(3, 1'b0);

      // interboard_rst in WAIT abandons the transaction without done.
      randomize_msgs();
      req = 4'b0010;
      tick();
      req = '0;
      tick();
      chk("ibr_wait_busy", busy, 1'b1);
      interboard_rst = 1'b1;
      tick();
      interboard_rst = 1'b0;
      chk("ibr_busy", busy, 1'b0);
      chk("ibr_grant", grant, '0);
      chk("ibr_done", done, '0);
      chk("ibr_msg", inter_msg, '0);
      m_ptr = N - 1;
      idle_cycles(2, 1'b0);
      randomize_msgs();
      run_txn(4'b1111, 0, 0, 1'b0);
      chk("ibr_ptr", last_grant, 4'b0001);

      // Asynchronous rst mid-cycle clears outputs without waiting for an edge.
      randomize_msgs();
      req = 4'b0100;
      tick();
      req = '0;
      tick();
      #3;
      rst = 1'b1;
      #1;
      chk("arst_busy", busy, 1'b0);
      chk("arst_grant", grant, '0);
      chk("arst_msg", inter_msg, '0);
      #1;
      rst = 1'b0;
      m_ptr = N - 1;
      tick();
      idle_cycles(1, 1'b0);

      // Randomized traffic.
      for (int n = 0; n < 40; n++) begin
         logic [N-1:0] rq;
         rq = N'($urandom_range(1, (1 << N) - 1));
         randomize_msgs();
         run_txn(rq, $urandom_range(0, MR + 1), $urandom_range(0, T - 1), 1'b1);
         if ($urandom_range(3) == 0) idle_cycles($urandom_range(1, 3), 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
